// File: rtl/alarm_annunciator_pkg.sv
// Shared definitions for the alarm annunciator: state encodings, state width and a sizing helper.
package alarm_annunciator_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_PRE_ALARM = 3'd2,
        ST_SOUNDING  = 3'd3,
        ST_SILENCED  = 3'd4,
        ST_TIMEOUT   = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_annunciator_tick_gen.sv
// Free-running tick generator: pulses o_Tick while the counter sits at CLKS_PER_TICK-1;
// i_Clear restarts the count so a new timed phase always begins on a fresh tick boundary.
module alarm_annunciator_tick_gen #(
    parameter int CLKS_PER_TICK = 12_500_000
) (
    input  logic i_Clk,
    input  logic i_Reset_n,
    input  logic i_Clear,
    output logic o_Tick
);

    localparam int               CNT_W = $clog2(CLKS_PER_TICK);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on request, wrap at terminal, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == TERM) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Tick = (cnt_q == TERM);

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: grace delay, blinking siren, acknowledge/silence and sound timeout.
// Optional o_Event_Count port and counter are built when ALARM_EVENT_COUNT_EN is defined.
module alarm_annunciator
    import alarm_annunciator_pkg::*;
#(
    parameter int CLKS_PER_TICK = 12_500_000,
    parameter int GRACE_TICKS   = 10,
    parameter int SOUND_TICKS   = 120
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic               i_Armed,
    input  logic               i_Alarm,
    input  logic               i_Ack,
    output logic               o_Siren,
    output logic               o_Strobe,
    output logic [STATE_W-1:0] o_State
`ifdef ALARM_EVENT_COUNT_EN
    ,
    output logic [3:0]         o_Event_Count
`endif
);

    localparam int                TICKS_MAX  = max_int(GRACE_TICKS, SOUND_TICKS);
    localparam int                TCNT_W     = $clog2(TICKS_MAX + 1);
    localparam logic [TCNT_W-1:0] GRACE_LAST = TCNT_W'(GRACE_TICKS - 1);
    localparam logic [TCNT_W-1:0] SOUND_LAST = TCNT_W'(SOUND_TICKS - 1);
    localparam logic [TCNT_W-1:0] TCNT_SAT   = TCNT_W'(TICKS_MAX);

    state_e            state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              phase_q, phase_d;
    logic              siren_q, siren_d;
    logic              strobe_q, strobe_d;
    logic              tick_s;
    logic              state_chg_s;
    logic              grace_done_s;
    logic              sound_done_s;

    alarm_annunciator_tick_gen #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_tick_gen (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (state_chg_s),
        .o_Tick    (tick_s)
    );

    // The expiring tick itself triggers the move, so the count never reaches its limit in-state.
    assign grace_done_s = tick_s && (tcnt_q == GRACE_LAST);
    assign sound_done_s = tick_s && (tcnt_q == SOUND_LAST);
    assign state_chg_s  = (state_d != state_q);

    // Next-state logic; disarm > ack > alarm drop > tick expiry.
    always_comb begin
        state_d = state_q;
        if (!i_Armed) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_ARMED;
                ST_ARMED:     state_d = i_Alarm ? ST_PRE_ALARM : ST_ARMED;
                ST_PRE_ALARM: begin
                    if (i_Ack) begin
                        state_d = ST_SILENCED;
                    end else if (!i_Alarm) begin
                        state_d = ST_ARMED;
                    end else if (grace_done_s) begin
                        state_d = ST_SOUNDING;
                    end else begin
                        state_d = ST_PRE_ALARM;
                    end
                end
                ST_SOUNDING: begin
                    if (i_Ack) begin
                        state_d = ST_SILENCED;
                    end else if (sound_done_s) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        state_d = ST_SOUNDING;
                    end
                end
                ST_SILENCED:  state_d = i_Alarm ? ST_SILENCED : ST_ARMED;
                ST_TIMEOUT:   state_d = (i_Ack || !i_Alarm) ? ST_ARMED : ST_TIMEOUT;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Tick count and blink phase restart on entry to every state; phase starts high.
    always_comb begin
        tcnt_d  = tcnt_q;
        phase_d = phase_q;
        if (state_chg_s) begin
            tcnt_d  = {TCNT_W{1'b0}};
            phase_d = 1'b1;
        end else if (tick_s) begin
            phase_d = ~phase_q;
            tcnt_d  = (tcnt_q == TCNT_SAT) ? tcnt_q : tcnt_q + TCNT_W'(1);
        end else begin
            tcnt_d  = tcnt_q;
            phase_d = phase_q;
        end
    end

    // Output decode from next state so the drives are registered alongside the state.
    always_comb begin
        siren_d = (state_d == ST_SOUNDING) && phase_d;
        case (state_d)
            ST_ARMED, ST_SOUNDING, ST_TIMEOUT: strobe_d = 1'b1;
            ST_PRE_ALARM, ST_SILENCED:         strobe_d = phase_d;
            default:                           strobe_d = 1'b0;
        endcase
    end

    // FSM, counters and output registers.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= ST_IDLE;
            tcnt_q   <= {TCNT_W{1'b0}};
            phase_q  <= 1'b0;
            siren_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            phase_q  <= phase_d;
            siren_q  <= siren_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_Siren  = siren_q;
    assign o_Strobe = strobe_q;
    assign o_State  = state_q;

`ifdef ALARM_EVENT_COUNT_EN
    logic [3:0] evt_q;

    // Saturating count of grace-expiry (sounding) entries; cleared only by reset.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            evt_q <= 4'd0;
        end else if ((state_q == ST_PRE_ALARM) && (state_d == ST_SOUNDING) && (evt_q != 4'd15)) begin
            evt_q <= evt_q + 4'd1;
        end else begin
            evt_q <= evt_q;
        end
    end

    assign o_Event_Count = evt_q;
`endif

endmodule
